// File: rtl/screen_flow_ctrl.sv
// Full-screen page sequencer with key debounce and hint blink.
// All page changes and counters advance on frame_tick only.
module screen_flow_ctrl #(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int BLINK_FRAMES    = 30,
  parameter int ACK_TIMEOUT     = 600,
  parameter int OVER_FRAMES     = 180,
  parameter int CNT_W           = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       key_start,
  input  logic       key_back,
  input  logic       game_over,
  output logic [1:0] screen_sel,
  output logic       hint_on,
  output logic       game_run,
  output logic       game_rst
);

  typedef enum logic [1:0] {
    ST_WELCOME = 2'd0,
    ST_ACK     = 2'd1,
    ST_PLAY    = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  localparam int DB_W = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [DB_W-1:0] DB_FULL =
    DB_W'(DEBOUNCE_FRAMES);
  localparam logic [DB_W-1:0] DB_LAST =
    DB_W'(DEBOUNCE_FRAMES - 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] ACK_LAST =
    CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] OVER_LAST =
    CNT_W'(OVER_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LEN =
    CNT_W'(BLINK_FRAMES);
  localparam logic [CNT_W-1:0] BLINK_LAST =
    CNT_W'(BLINK_FRAMES - 1);

  logic [1:0]       start_sync;
  logic [1:0]       back_sync;
  logic [DB_W-1:0]  start_db;
  logic [DB_W-1:0]  back_db;
  logic             start_evt;
  logic             back_evt;
  logic             start_pend;
  logic             back_pend;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] frame_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             hint_nxt;
  logic             rst_nxt;
  logic             state_chg;
  logic             blink_wrap;

  // Two-flop synchronisers for the raw front-panel keys.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync <= '0;
      back_sync  <= '0;
    end else begin
      start_sync <= {start_sync[0], key_start};
      back_sync  <= {back_sync[0], key_back};
    end
  end

  // A press fires once, on the tick the hold count reaches full.
  assign start_evt = frame_tick & start_sync[1] &
                     (start_db == DB_LAST);
  assign back_evt  = frame_tick & back_sync[1] &
                     (back_db == DB_LAST);

  // Per-frame hold counters; pending flags hold one frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_db   <= '0;
      back_db    <= '0;
      start_pend <= 1'b0;
      back_pend  <= 1'b0;
    end else if (frame_tick) begin
      if (!start_sync[1])
        start_db <= '0;
      else if (start_db != DB_FULL)
        start_db <= start_db + 1'b1;
      if (!back_sync[1])
        back_db <= '0;
      else if (back_db != DB_FULL)
        back_db <= back_db + 1'b1;
      start_pend <= start_evt;
      back_pend  <= back_evt;
    end
  end

  // State, frame counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_WELCOME;
      frame_cnt <= '0;
      hint_on   <= 1'b1;
      game_rst  <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= cnt_nxt;
      hint_on   <= hint_nxt;
      game_rst  <= rst_nxt;
    end
  end

  // Page transitions, evaluated only on frame ticks.
  always_comb begin
    state_nxt = state;
    if (frame_tick) begin
      unique case (state)
        ST_WELCOME: begin
          if (start_pend)
            state_nxt = ST_ACK;
        end
        ST_ACK: begin
          if (start_pend)
            state_nxt = ST_PLAY;
          else if (back_pend)
            state_nxt = ST_WELCOME;
          else if (frame_cnt == ACK_LAST)
            state_nxt = ST_WELCOME;
        end
        ST_PLAY: begin
          if (game_over)
            state_nxt = ST_OVER;
        end
        ST_OVER: begin
          if (start_pend)
            state_nxt = ST_WELCOME;
          else if (frame_cnt == OVER_LAST)
            state_nxt = ST_WELCOME;
        end
      endcase
    end
  end

  assign blink_wrap =
    (frame_cnt % BLINK_LEN) == BLINK_LAST;

  // Next counter/blink/pulse values and page decode.
  always_comb begin
    state_chg = (state_nxt != state);
    cnt_nxt   = frame_cnt;
    hint_nxt  = hint_on;
    rst_nxt   = (state_nxt == ST_PLAY) &&
                (state != ST_PLAY);
    if (frame_tick) begin
      if (state_chg) begin
        cnt_nxt  = '0;
        hint_nxt = 1'b1;
      end else begin
        if (frame_cnt != CNT_MAX)
          cnt_nxt = frame_cnt + 1'b1;
        if (blink_wrap)
          hint_nxt = ~hint_on;
      end
    end
    if (state_nxt == ST_PLAY)
      hint_nxt = 1'b0;
    screen_sel = state;
    game_run   = (state == ST_PLAY);
  end

endmodule
